// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus frame scheduler that drives the UART transmit FSM (tx_control).
// Optional build macro UART_TX_FEEDER_OVF_CNT_EN adds a saturating dropped-write counter (ovf_cnt).
module uart_tx_feeder #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              ovf_clr,
`ifdef UART_TX_FEEDER_OVF_CNT_EN
   output logic [7:0]        ovf_cnt,
`endif
   input  logic              bps_clk_total,
   input  logic              tx_done,
   output logic [7:0]        tx_data,
   output logic              tx_enable,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t            state, state_nx;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count_nx;
   logic [7:0]        head;
   logic              pop, push, drop;

   assign head = mem[rd_ptr];
   // A pop in the same cycle frees a slot, so a write at full is still accepted.
   assign push = wr_en && (!full || pop);
   assign drop = wr_en && !push;
   assign busy = (state != IDLE);

   always_comb begin
      state_nx  = state;
      pop       = 1'b0;
      tx_enable = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               state_nx = SEND;
            end
         end
         SEND: begin
            tx_enable = 1'b1;
            if (tx_done) begin
               if (!empty) pop = 1'b1;
               else         state_nx = DRAIN;
            end
         end
         DRAIN: begin
            // Enable falls exactly at stop-bit end so the FSM idles instead of restarting.
            tx_enable = ~bps_clk_total;
            if (bps_clk_total) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Reset abandons a frame in the very cycle it is asserted.
      if (!rst) tx_enable = 1'b0;
   end

   always_comb begin
      count_nx = count;
      case ({push, pop})
         2'b10:   count_nx = count + (ADDR_W+1)'(1);
         2'b01:   count_nx = count - (ADDR_W+1)'(1);
         default: count_nx = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst && push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         tx_data <= 8'h00;
      end else begin
         state <= state_nx;
         count <= count_nx;
         full  <= (count_nx == DEPTH_C);
         empty <= (count_nx == '0);
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + ADDR_W'(1);
            tx_data <= head;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)         overflow <= 1'b0;
      else if (ovf_clr) overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
   end

`ifdef UART_TX_FEEDER_OVF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst)                           ovf_cnt <= 8'h00;
      else if (ovf_clr)                   ovf_cnt <= 8'h00;
      else if (drop && ovf_cnt != 8'hFF)  ovf_cnt <= ovf_cnt + 8'h01;
   end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench: a behavioural UART line model consumes frames and checks each byte
// against the queue of accepted writes; directed phases cover latency, overflow and reset.
module tb_uart_tx_feeder;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int BIT    = 4;

   logic              clk = 1'b0, rst = 1'b0, wr_en = 1'b0, ovf_clr = 1'b0;
   logic              bps = 1'b0, tx_done = 1'b0;
   logic [7:0]        wr_data = 8'h00;
   logic              full, empty, overflow, tx_enable, busy;
   logic [ADDR_W:0]   count;
   logic [7:0]        tx_data;
`ifdef UART_TX_FEEDER_OVF_CNT_EN
   logic [7:0]        ovf_cnt;
`endif

   uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count), .overflow(overflow), .ovf_clr(ovf_clr),
`ifdef UART_TX_FEEDER_OVF_CNT_EN
      .ovf_cnt(ovf_cnt),
`endif
      .bps_clk_total(bps), .tx_done(tx_done), .tx_data(tx_data),
      .tx_enable(tx_enable), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [7:0] exp_q[$];
   int trains = 0;
   bit hold = 1'b0;

   typedef enum {M_IDLE, M_BITS, M_STOP} mst_t;
   mst_t ms = M_IDLE;
   int   ticks = 0, div = 0;
   bit   pend_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor side: a new frame starts, so the byte on tx_data must be the oldest expected one.
   task automatic start_frame();
      logic [7:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL frame_unexpected: got %0h expected none", tx_data);
      end else begin
         e = exp_q.pop_front();
         if (tx_data !== e) begin
            failures++;
            $display("FAIL frame_data: got %0h expected %0h", tx_data, e);
         end
      end
      ms    = M_BITS;
      ticks = 0;
   endtask

   // Line model: start bit + 8 data bits, tx_done on stop-bit entry, stop ends on a bit tick.
   initial begin
      forever begin
         @(posedge clk); #1;
         bps       = (div == BIT-1);
         div       = (div + 1) % BIT;
         tx_done   = pend_done;
         pend_done = 1'b0;
         @(negedge clk);
         if (!rst) begin
            ms        = M_IDLE;
            pend_done = 1'b0;
         end else begin
            case (ms)
               M_IDLE: if (tx_enable) start_frame();
               M_BITS: if (bps && !hold) begin
                  ticks++;
                  if (ticks == 9) begin
                     pend_done = 1'b1;
                     ms        = M_STOP;
                  end
               end
               M_STOP: if (bps) begin
                  if (tx_enable) start_frame();
                  else begin
                     ms = M_IDLE;
                     trains++;
                  end
               end
               default: ms = M_IDLE;
            endcase
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #2;
   endtask

   task automatic wr(input logic [7:0] b, input bit expect_accept);
      wr_en   = 1'b1;
      wr_data = b;
      if (expect_accept) exp_q.push_back(b);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (tx_done) begin seen = 1'b1; break; end
         cyc();
      end
      chk("wait_done_timeout", 32'(seen), 32'd1);
   endtask

   task automatic wait_bits();
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ms == M_BITS) begin seen = 1'b1; break; end
         cyc();
      end
      chk("wait_frame_timeout", 32'(seen), 32'd1);
   endtask

   task automatic wait_idle();
      bit seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (exp_q.size() == 0 && !busy && ms == M_IDLE) begin seen = 1'b1; break; end
         cyc();
      end
      chk("wait_idle_timeout", 32'(seen), 32'd1);
   endtask

   initial begin
      int t0;
      logic [7:0] b2b [3];
      b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33;

      // Reset state
      repeat (3) cyc();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'h00);
      chk("rst_tx_enable", 32'(tx_enable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      cyc();

      // Single byte latency
      t0 = trains;
      wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
      cyc(); wr_en = 1'b0;
      chk("lat1_count", 32'(count), 32'd1);
      chk("lat1_empty", 32'(empty), 32'd0);
      chk("lat1_tx_enable", 32'(tx_enable), 32'd0);
      cyc();
      chk("lat2_tx_data", 32'(tx_data), 32'hA5);
      chk("lat2_tx_enable", 32'(tx_enable), 32'd1);
      chk("lat2_busy", 32'(busy), 32'd1);
      wait_idle();
      chk("single_trains", 32'(trains - t0), 32'd1);
      chk("single_enable_off", 32'(tx_enable), 32'd0);

      // Back-to-back frames
      t0 = trains;
      for (int k = 0; k < 3; k++) wr(b2b[k], 1'b1);
      for (int k = 0; k < 2; k++) begin
         wait_done();
         cyc();
         chk("b2b_tx_data", 32'(tx_data), 32'(b2b[k+1]));
         chk("b2b_tx_enable", 32'(tx_enable), 32'd1);
      end
      wait_idle();
      chk("b2b_trains", 32'(trains - t0), 32'd1);

      // Full / overflow with the line stalled mid-frame
      wr(8'h80, 1'b1);
      wait_bits();
      hold = 1'b1;
      for (int k = 0; k < DEPTH; k++) wr(8'(8'h81 + k), 1'b1);
      wr(8'hEE, 1'b0);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
`ifdef UART_TX_FEEDER_OVF_CNT_EN
      chk("ovf_cnt_one", 32'(ovf_cnt), 32'd1);
`endif
      ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
`ifdef UART_TX_FEEDER_OVF_CNT_EN
      chk("ovf_cnt_cleared", 32'(ovf_cnt), 32'd0);
`endif
      ovf_clr = 1'b1; wr(8'hEF, 1'b0); ovf_clr = 1'b0;
      chk("ovf_clr_priority", 32'(overflow), 32'd0);
`ifdef UART_TX_FEEDER_OVF_CNT_EN
      chk("ovf_cnt_clr_priority", 32'(ovf_cnt), 32'd0);
`endif
      chk("ovf_count_kept", 32'(count), 32'd16);
      hold = 1'b0;
      wait_done();
      wr(8'hC3, 1'b1);
      chk("pushpop_count", 32'(count), 32'd16);
      chk("pushpop_full", 32'(full), 32'd1);
      chk("pushpop_overflow", 32'(overflow), 32'd0);
      wait_idle();
      chk("drain_empty", 32'(empty), 32'd1);

      // Late write lands during DRAIN
      t0 = trains;
      wr(8'h44, 1'b1);
      wait_done();
      cyc();
      chk("late_busy", 32'(busy), 32'd1);
      wr(8'h5A, 1'b1);
      wait_idle();
      chk("late_trains", 32'(trains - t0), 32'd2);

      // Mid-frame reset
      for (int k = 0; k < 4; k++) wr(8'(8'h90 + k), 1'b1);
      wait_bits();
      hold = 1'b1;
      cyc();
      chk("mrst_queued", 32'(count), 32'd3);
      rst = 1'b0;
      #1;
      chk("mrst_enable_now", 32'(tx_enable), 32'd0);
      exp_q.delete();
      hold = 1'b0;
      cyc();
      rst = 1'b1;
      chk("mrst_tx_enable", 32'(tx_enable), 32'd0);
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_empty", 32'(empty), 32'd1);
      chk("mrst_tx_data", 32'(tx_data), 32'h00);
      chk("mrst_busy", 32'(busy), 32'd0);
      wr(8'h3C, 1'b1);
      wait_idle();

      // Randomized traffic, kept below the full threshold
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 12)) cyc();
         if (exp_q.size() < DEPTH - 2) wr(8'($urandom_range(0, 255)), 1'b1);
         else cyc();
      end
      wait_idle();
      chk("rand_overflow", 32'(overflow), 32'd0);
      chk("rand_empty", 32'(empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
